// File: rtl/cpu_reg_package.sv
// rtl/cpu_reg_package.sv - shared CPU peripheral address map and timer register layout
package cpu_reg_package;

  typedef enum logic [2:0] {
    uart_e,
    gpio_e,
    timer_e,
    spi_e
  } peripheral_e;

  localparam int unsigned PeripheralWindow = 32'h100;

  function automatic logic [31:0] get_address_start(input peripheral_e p);
    return 32'(p) * PeripheralWindow;
  endfunction

  function automatic logic [31:0] get_address_end(input peripheral_e p);
    return get_address_start(p) + PeripheralWindow - 32'd1;
  endfunction

  // Timer register indices; byte address is BaseAddress + index * Address_Wording
  localparam int unsigned CTRL     = 0;
  localparam int unsigned LOAD     = 1;
  localparam int unsigned COUNT    = 2;
  localparam int unsigned STATUS   = 3;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned NUM_REGS = 5;

  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;
  localparam int unsigned STATUS_EXPIRED   = 0;
  localparam int unsigned PRESCALE_WIDTH   = 16;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running prescale counter producing the timer tick
module timer_prescaler
  import cpu_reg_package::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] count;

  // A clear cycle never ticks, so a software COUNT write always beats the tick.
  assign tick = enable && !clear && (count == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || clear || tick) begin
      count <= '0;
    end else begin
      count <= count + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_cpu.sv
// rtl/timer_cpu.sv - CPU-mapped down-counting timer with prescaler, auto-reload and IRQ
module timer_cpu
  import cpu_reg_package::*;
#(
  parameter int unsigned BaseAddress     = 0,
  parameter int unsigned address_width   = 32,
  parameter int unsigned data_width      = 32,
  parameter int unsigned Address_Wording = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
  output logic [data_width-1:0]    data_o,
  output logic                     irq_o
);

  logic [NUM_REGS-1:0]       sel;
  logic                      wr_ctrl;
  logic                      wr_load;
  logic                      wr_count;
  logic                      wr_status;
  logic                      wr_prescale;

  logic                      ctrl_en;
  logic                      ctrl_auto_reload;
  logic                      ctrl_irq_en;
  logic [data_width-1:0]     load_q;
  logic [data_width-1:0]     count_q;
  logic                      expired;
  logic [PRESCALE_WIDTH-1:0] prescale_q;

  logic                      en_rise;
  logic                      tick;
  logic                      expire;
  logic [data_width-1:0]     rdata;

  always_comb begin
    sel = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      sel[n] = (address_i == address_width'(BaseAddress + n * Address_Wording));
    end
  end

  assign wr_ctrl     = rd_wr_i && sel[CTRL];
  assign wr_load     = rd_wr_i && sel[LOAD];
  assign wr_count    = rd_wr_i && sel[COUNT];
  assign wr_status   = rd_wr_i && sel[STATUS];
  assign wr_prescale = rd_wr_i && sel[PRESCALE];

  assign en_rise = wr_ctrl && data_i[CTRL_EN] && !ctrl_en;
  assign expire  = tick && (count_q == '0);

  timer_prescaler u_prescaler (
    .clk      (clk_i),
    .rst_n    (reset_n_i),
    .enable   (ctrl_en),
    .clear    (wr_count || en_rise),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_comb begin
    rdata = '0;
    if (sel[CTRL]) begin
      rdata[CTRL_EN]          = ctrl_en;
      rdata[CTRL_AUTO_RELOAD] = ctrl_auto_reload;
      rdata[CTRL_IRQ_EN]      = ctrl_irq_en;
    end
    if (sel[LOAD])     rdata = load_q;
    if (sel[COUNT])    rdata = count_q;
    if (sel[STATUS])   rdata[STATUS_EXPIRED] = expired;
    if (sel[PRESCALE]) rdata[PRESCALE_WIDTH-1:0] = prescale_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctrl_en          <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      ctrl_irq_en      <= 1'b0;
      load_q           <= '0;
      count_q          <= '0;
      expired          <= 1'b0;
      prescale_q       <= '0;
      data_o           <= '0;
      irq_o            <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en          <= data_i[CTRL_EN];
        ctrl_auto_reload <= data_i[CTRL_AUTO_RELOAD];
        ctrl_irq_en      <= data_i[CTRL_IRQ_EN];
      end else if (expire && !ctrl_auto_reload) begin
        ctrl_en <= 1'b0;
      end

      if (wr_load)     load_q     <= data_i;
      if (wr_prescale) prescale_q <= data_i[PRESCALE_WIDTH-1:0];

      // Reload uses the LOAD value held before this edge, so a same-cycle LOAD write waits.
      if (wr_count) begin
        count_q <= data_i;
      end else if (tick) begin
        if (count_q != '0) begin
          count_q <= count_q - data_width'(1);
        end else if (ctrl_auto_reload) begin
          count_q <= load_q;
        end
      end

      expired <= (expired && !(wr_status && data_i[STATUS_EXPIRED])) || expire;
      irq_o   <= expired && ctrl_irq_en;
      data_o  <= rdata;
    end
  end

endmodule

// File: tb/tb_timer_cpu.sv
// tb/tb_timer_cpu.sv - self-checking bench for timer_cpu
module tb_timer_cpu;

  localparam logic [31:0] A_CTRL   = 32'd0;
  localparam logic [31:0] A_LOAD   = 32'd4;
  localparam logic [31:0] A_COUNT  = 32'd8;
  localparam logic [31:0] A_STATUS = 32'd12;
  localparam logic [31:0] A_PRE    = 32'd16;
  localparam logic [31:0] A_OUT    = 32'd20;
  localparam logic [31:0] A_IDLE   = 32'h0000_1000;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [31:0] address_i = A_IDLE;
  logic [31:0] data_i = '0;
  logic        rd_wr_i = 1'b0;
  logic [31:0] data_o;
  logic        irq_o;

  timer_cpu dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .address_i (address_i),
    .data_i    (data_i),
    .rd_wr_i   (rd_wr_i),
    .data_o    (data_o),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[10];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // One bus cycle: drive at a falling edge, the DUT acts on the rising edge, read data is scored next falling edge.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                     input logic rd, input logic [31:0] exp, input string name);
    exp_t e;
    address_i = addr;
    data_i    = wdata;
    rd_wr_i   = wr;
    if (rd) exp_q.push_back('{name: name, value: exp});
    @(negedge clk_i);
    rd_wr_i   = 1'b0;
    address_i = A_IDLE;
    if (rd) begin
      if (exp_q.size() == 0) begin
        check({name, "_scoreboard"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check(e.name, data_o, e.value);
      end
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    bus(addr, wdata, 1'b1, 1'b0, '0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus(addr, '0, 1'b0, 1'b1, exp, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(A_IDLE, '0, 1'b0, 1'b0, '0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ar_seq [12];
    logic        irq_seen;

    vecs[0] = '{A_PRE,   32'h0000_1234, 32'h0000_1234, "prescale_1234"};
    vecs[1] = '{A_PRE,   32'hABCD_5678, 32'h0000_5678, "prescale_trunc"};
    vecs[2] = '{A_LOAD,  32'hDEAD_BEEF, 32'hDEAD_BEEF, "load_full"};
    vecs[3] = '{A_COUNT, 32'h0000_0007, 32'h0000_0007, "count_idle"};
    vecs[4] = '{A_CTRL,  32'hFFFF_FFFA, 32'h0000_0002, "ctrl_mask"};
    vecs[5] = '{A_CTRL,  32'h0000_0004, 32'h0000_0004, "ctrl_irq_en"};
    vecs[6] = '{A_STATUS, 32'h0000_0001, 32'h0000_0000, "status_w1c_idle"};
    vecs[7] = '{A_OUT,   32'hFFFF_FFFF, 32'h0000_0000, "outside_window"};
    vecs[8] = '{32'd6,   32'h1111_1111, 32'h0000_0000, "misaligned"};
    vecs[9] = '{A_CTRL,  32'h0000_0000, 32'h0000_0000, "ctrl_zero"};

    @(negedge clk_i);
    check("reset_data_o", data_o, 32'd0);
    check("reset_irq_o", {31'b0, irq_o}, 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    rd(A_CTRL, 0, "reset_ctrl");
    rd(A_LOAD, 0, "reset_load");
    rd(A_COUNT, 0, "reset_count");
    rd(A_STATUS, 0, "reset_status");
    rd(A_PRE, 0, "reset_prescale");

    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    rd(A_LOAD, 32'hDEAD_BEEF, "load_untouched");
    rd(A_PRE, 32'h0000_5678, "prescale_untouched");

    // One-shot
    wr(A_PRE, 0);
    wr(A_COUNT, 3);
    wr(A_CTRL, 5);
    rd(A_COUNT, 3, "oneshot_c3");
    rd(A_COUNT, 2, "oneshot_c2");
    rd(A_COUNT, 1, "oneshot_c1");
    rd(A_COUNT, 0, "oneshot_c0");
    check("oneshot_irq_lag", {31'b0, irq_o}, 32'd0);
    rd(A_STATUS, 1, "oneshot_expired");
    check("oneshot_irq", {31'b0, irq_o}, 32'd1);
    rd(A_CTRL, 4, "oneshot_en_cleared");
    idle(3);
    rd(A_COUNT, 0, "oneshot_count_hold");
    wr(A_STATUS, 0);
    rd(A_STATUS, 1, "status_w0_noeffect");
    wr(A_STATUS, 1);
    rd(A_STATUS, 0, "status_w1c");
    check("irq_cleared", {31'b0, irq_o}, 32'd0);

    // Auto-reload: each COUNT value lasts two cycles, expiry every six
    ar_seq = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0};
    wr(A_PRE, 1);
    wr(A_LOAD, 2);
    wr(A_COUNT, 2);
    wr(A_CTRL, 7);
    for (int i = 0; i < 12; i++) rd(A_COUNT, ar_seq[i], $sformatf("autoreload_%0d", i));
    check("autoreload_irq", {31'b0, irq_o}, 32'd1);
    wr(A_STATUS, 1);
    rd(A_STATUS, 0, "autoreload_w1c");
    check("autoreload_irq_cleared", {31'b0, irq_o}, 32'd0);
    idle(3);
    wr(A_STATUS, 1);
    rd(A_STATUS, 1, "set_wins");
    check("set_wins_irq", {31'b0, irq_o}, 32'd1);
    wr(A_CTRL, 0);
    wr(A_STATUS, 1);

    // COUNT write priority and prescaler restart
    wr(A_PRE, 1);
    wr(A_COUNT, 5);
    wr(A_CTRL, 1);
    idle(1);
    wr(A_COUNT, 10);
    rd(A_COUNT, 10, "prio_c10a");
    rd(A_COUNT, 10, "prio_c10b");
    rd(A_COUNT, 9, "prio_c9");
    idle(1);
    wr(A_COUNT, 20);
    rd(A_COUNT, 20, "restart_c20a");
    rd(A_COUNT, 20, "restart_c20b");
    rd(A_COUNT, 19, "restart_c19");
    wr(A_CTRL, 0);

    // LOAD written on the expiry cycle: the reload uses the old LOAD
    wr(A_PRE, 0);
    wr(A_LOAD, 5);
    wr(A_COUNT, 0);
    wr(A_CTRL, 3);
    wr(A_LOAD, 9);
    rd(A_COUNT, 5, "load_old_used");
    idle(5);
    rd(A_COUNT, 9, "load_new_used");

    // Asynchronous reset mid-countdown
    wr(A_CTRL, 7);
    rd(A_STATUS, 1, "pre_reset_status");
    check("pre_reset_irq", {31'b0, irq_o}, 32'd1);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_reset_data", data_o, 32'd0);
    check("async_reset_irq", {31'b0, irq_o}, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    irq_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (irq_o) irq_seen = 1'b1;
    end
    check("post_reset_no_irq", {31'b0, irq_seen}, 32'd0);
    rd(A_CTRL, 0, "post_reset_ctrl");
    rd(A_COUNT, 0, "post_reset_count");
    rd(A_STATUS, 0, "post_reset_status");
    rd(A_LOAD, 0, "post_reset_load");
    rd(A_PRE, 0, "post_reset_prescale");
    wr(A_COUNT, 32'h55);
    rd(A_COUNT, 32'h55, "post_reset_write");

    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
